tc0_output_compare: RTL

Output-compare and waveform-generation stage of Timer/Counter0, directly downstream of the counter and its control logic. It holds the double-buffered OCR0A/OCR0B registers, detects compare matches against the live count, and drives the `oca_data`/`ocb_data` waveform pins. It raises one-cycle compare-match flags and publishes the active TOP value back to the control logic.

---
 rtl/tc0_pkg.sv | 31 +++
 rtl/tc0_oc_channel.sv | 90 +++++++++
 rtl/tc0_output_compare.sv | 78 +++++++
 3 files changed

// File: rtl/tc0_pkg.sv
// rtl/tc0_pkg.sv - Timer/Counter0 waveform modes, compare-output modes and mode helpers
package tc0_pkg;

  typedef enum logic [2:0] {
    WGM_NORMAL    = 3'd0,
    WGM_PC_FF     = 3'd1,
    WGM_CTC       = 3'd2,
    WGM_FAST_FF   = 3'd3,
    WGM_PC_OCRA   = 3'd5,
    WGM_FAST_OCRA = 3'd7
  } wgm_e;

  typedef enum logic [1:0] {
    COM_NONE   = 2'd0,
    COM_TOGGLE = 2'd1,
    COM_CLEAR  = 2'd2,
    COM_SET    = 2'd3
  } com_e;

  localparam logic [7:0] TC0_MAX = 8'hFF;

  // Odd modes are the PWM ones; reserved 4 and 6 fall out as non-PWM.
  function automatic logic is_pwm(input logic [2:0] wgm);
    return wgm[0];
  endfunction

  function automatic logic is_fast(input logic [2:0] wgm);
    return wgm[1] & wgm[0];
  endfunction

endpackage

// File: rtl/tc0_oc_channel.sv
// rtl/tc0_oc_channel.sv - one output-compare channel: OCR double buffer, match, COM action, pin and flag
module tc0_oc_channel
  import tc0_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit TOGGLE_PWM = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tcnt,
  input  logic             count,
  input  logic             direction,
  input  logic             bottom,
  input  logic [2:0]       wgm,
  input  logic [1:0]       com,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             foc,
  input  logic [WIDTH-1:0] top_value,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] act,
  output logic             oc_data,
  output logic             ocf
);

  logic [WIDTH-1:0] buf_q;
  logic [WIDTH-1:0] act_q;
  logic             oc_q;
  logic             ocf_q;
  logic             pwm;
  logic             fast;
  logic             match;
  logic             pwm_toggle;
  logic             load;
  logic             oc_next;

  always_comb begin
    pwm        = is_pwm(wgm);
    fast       = is_fast(wgm);
    match      = count && (tcnt == act_q);
    pwm_toggle = TOGGLE_PWM && (wgm == (fast ? WGM_FAST_OCRA : WGM_PC_OCRA));
    load       = !pwm || (count && (tcnt == top_value));
    oc_next    = oc_q;
    if (!pwm) begin
      // A force coinciding with a real match still applies the action once.
      if (match || foc) begin
        case (com)
          COM_TOGGLE: oc_next = ~oc_q;
          COM_CLEAR:  oc_next = 1'b0;
          COM_SET:    oc_next = 1'b1;
          default:    ;
        endcase
      end
    end else if (match) begin
      // The match is checked before bottom so it wins when both land on one tick.
      case (com)
        COM_TOGGLE: if (pwm_toggle) oc_next = ~oc_q;
        COM_CLEAR:  oc_next = fast ? 1'b0 : ~direction;
        COM_SET:    oc_next = fast ? 1'b1 : direction;
        default:    ;
      endcase
    end else if (fast && count && bottom) begin
      case (com)
        COM_CLEAR: oc_next = 1'b1;
        COM_SET:   oc_next = 1'b0;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
      act_q <= '0;
      oc_q  <= 1'b0;
      ocf_q <= 1'b0;
    end else begin
      if (wr) buf_q <= wdata;
      if (load) act_q <= buf_q;
      oc_q  <= oc_next;
      ocf_q <= match;
    end
  end

  assign rdata   = buf_q;
  assign act     = act_q;
  assign oc_data = (com != COM_NONE) & oc_q;
  assign ocf     = ocf_q;

endmodule

// File: rtl/tc0_output_compare.sv
// rtl/tc0_output_compare.sv - Timer/Counter0 output-compare stage: two channels plus the TOP mux
module tc0_output_compare
  import tc0_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tcnt,
  input  logic             count,
  input  logic             direction,
  input  logic             bottom,
  input  logic [2:0]       wgm,
  input  logic [1:0]       com_a,
  input  logic [1:0]       com_b,
  input  logic             ocr_a_wr,
  input  logic             ocr_b_wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             foc_a,
  input  logic             foc_b,
  output logic [WIDTH-1:0] ocr_a_rdata,
  output logic [WIDTH-1:0] ocr_b_rdata,
  output logic             oca_data,
  output logic             ocb_data,
  output logic             ocf_a,
  output logic             ocf_b,
  output logic [WIDTH-1:0] top_value
);

  logic [WIDTH-1:0] act_a;
  logic [WIDTH-1:0] act_b_unused;

  always_comb begin
    case (wgm)
      WGM_CTC, WGM_PC_OCRA, WGM_FAST_OCRA: top_value = act_a;
      default:                             top_value = '1;
    endcase
  end

  tc0_oc_channel #(.WIDTH(WIDTH), .TOGGLE_PWM(1'b1)) u_chan_a (
    .clk       (clk),
    .rst       (rst),
    .tcnt      (tcnt),
    .count     (count),
    .direction (direction),
    .bottom    (bottom),
    .wgm       (wgm),
    .com       (com_a),
    .wr        (ocr_a_wr),
    .wdata     (wdata),
    .foc       (foc_a),
    .top_value (top_value),
    .rdata     (ocr_a_rdata),
    .act       (act_a),
    .oc_data   (oca_data),
    .ocf       (ocf_a)
  );

  tc0_oc_channel #(.WIDTH(WIDTH), .TOGGLE_PWM(1'b0)) u_chan_b (
    .clk       (clk),
    .rst       (rst),
    .tcnt      (tcnt),
    .count     (count),
    .direction (direction),
    .bottom    (bottom),
    .wgm       (wgm),
    .com       (com_b),
    .wr        (ocr_b_wr),
    .wdata     (wdata),
    .foc       (foc_b),
    .top_value (top_value),
    .rdata     (ocr_b_rdata),
    .act       (act_b_unused),
    .oc_data   (ocb_data),
    .ocf       (ocf_b)
  );

endmodule
